nios_sd_dat_tx: RTL

//  Hardware SD 4-bit DAT write engine; Avalon-MM slave on the Nios bus replacing software bit-banging of DAT[3:0] for block writes.

---
 rtl/nios_sd_pkg.sv | 37 +++
 rtl/sd_crc16_line.sv | 31 +++
 rtl/nios_sd_dat_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_sd_pkg.sv
// Shared types and constants for the SD 4-bit DAT write engine.
// Build option: SD_DAT_CRC_STATUS_EN (token/busy reception states).
package nios_sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_TOKWAIT,
        ST_TOKEN,
        ST_BUSYWAIT
    } sd_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_REQ    = 1;
    localparam int STAT_DONE   = 2;
    localparam int STAT_CRCERR = 3;
    localparam int STAT_OVR    = 4;
    localparam int STAT_TOKERR = 5;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [2:0]  TOKEN_OK   = 3'b010;

    function automatic logic [15:0] crc16_step(input logic [15:0] c,
                                               input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_line.sv
// Serial CRC16 for one DAT line: clear, update with a payload bit,
// or shift the remainder out MSB first.
module sd_crc16_line
    import nios_sd_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    input  logic shift,
    output logic msb
);

    logic [15:0] crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end else if (shift) begin
            crc <= {crc[14:0], 1'b0};
        end
    end

    assign msb = crc[15];

endmodule

// File: rtl/nios_sd_dat_tx.sv
// SD 4-bit DAT block write engine with Avalon-MM register interface.
// Build option: SD_DAT_CRC_STATUS_EN adds CRC token and busy reception.
module nios_sd_dat_tx
    import nios_sd_pkg::*;
#(
    parameter int BLOCK_BYTES   = 512,
    parameter int CLK_DIV       = 4,
    parameter int TOKEN_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    inout  wire  [3:0]  bidir_port
);

    localparam int NIB   = 2 * BLOCK_BYTES;
    localparam int CMAX0 = (NIB > TOKEN_TIMEOUT) ? NIB : TOKEN_TIMEOUT;
    localparam int CMAX  = (CMAX0 > 16) ? CMAX0 : 16;
    localparam int CNT_W = $clog2(CMAX) + 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    sd_state_e        state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      shreg;
    logic [31:0]      hold;
    logic             hold_full;
    logic             stall;
    logic             bus_oe;
    logic [3:0]       bus_out;
    logic             done;
    logic             ovr;
    logic             crcerr;
    logic             tokerr;
`ifdef SD_DAT_CRC_STATUS_EN
    logic             quit;
    logic [2:0]       tok;
`endif

    logic        wr_data;
    logic        wr_start;
    logic        tick;
    logic        fall_ev;
    logic        rise_ev;
    logic        last_nib;
    logic        need_word;
    logic        go;
    logic        load;
    logic [3:0]  cur_nib;
    logic        crc_en;
    logic        crc_shift;
    logic [3:0]  crc_msb;
    logic [31:0] status;

    assign wr_data  = chipselect && !write_n && address == ADDR_DATA;
    assign wr_start = chipselect && !write_n && address == ADDR_CTRL
                      && writedata[0] && state == ST_IDLE;

    assign tick    = state != ST_IDLE && div_cnt == DIV_W'(CLK_DIV - 1);
    assign fall_ev = tick && sd_clk;
    assign rise_ev = tick && !sd_clk && !stall;

    assign last_nib  = cnt == CNT_W'(NIB - 1);
    assign need_word = state == ST_START
                       || (state == ST_DATA && cnt[2:0] == 3'd7 && !last_nib);
    // A stalled bit retries its advance on every tick until a word arrives.
    assign go        = (fall_ev || (tick && stall))
                       && (hold_full || !need_word);
    assign load      = go && need_word;
    assign cur_nib   = load ? hold[31:28] : shreg[31:28];

    assign crc_en    = go && (state == ST_START
                              || (state == ST_DATA && !last_nib));
    assign crc_shift = go && ((state == ST_DATA && last_nib)
                              || (state == ST_CRC && cnt != CNT_W'(15)));

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16_line u_crc (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (wr_start),
            .en      (crc_en),
            .din     (cur_nib[i]),
            .shift   (crc_shift),
            .msb     (crc_msb[i])
        );
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY]     = state != ST_IDLE;
        status[STAT_REQ]      = !hold_full;
        status[STAT_DONE]     = done;
        status[STAT_CRCERR]   = crcerr;
        status[STAT_OVR]      = ovr;
        status[STAT_TOKERR]   = tokerr;
    end

    assign bidir_port = bus_oe ? bus_out : 4'bzzzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            cnt       <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            stall     <= 1'b0;
            bus_oe    <= 1'b0;
            bus_out   <= 4'h0;
            sd_clk    <= 1'b0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            crcerr    <= 1'b0;
            tokerr    <= 1'b0;
            readdata  <= '0;
`ifdef SD_DAT_CRC_STATUS_EN
            quit      <= 1'b0;
            tok       <= 3'b000;
`endif
        end else begin
            readdata <= (address == ADDR_STATUS) ? status : 32'h0;

            if (load) hold_full <= 1'b0;
            if (wr_data) begin
                if (!hold_full || load) begin
                    hold      <= writedata;
                    hold_full <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end

            if (state == ST_IDLE || tick) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 1'b1;

            if (rise_ev) sd_clk <= 1'b1;
            if (fall_ev) sd_clk <= 1'b0;
            if (fall_ev || (tick && stall)) stall <= !go;

            unique case (state)
                ST_IDLE: begin
                    if (wr_start) begin
                        state   <= ST_START;
                        bus_oe  <= 1'b1;
                        bus_out <= 4'h0;
                        cnt     <= '0;
                        done    <= 1'b0;
                        ovr     <= 1'b0;
                        crcerr  <= 1'b0;
                        tokerr  <= 1'b0;
`ifdef SD_DAT_CRC_STATUS_EN
                        quit    <= 1'b0;
`endif
                    end
                end
                ST_START, ST_DATA: begin
                    if (go) begin
                        if (state == ST_DATA && last_nib) begin
                            state   <= ST_CRC;
                            cnt     <= '0;
                            bus_out <= crc_msb;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= (state == ST_START) ? '0 : cnt + 1'b1;
                            bus_out <= cur_nib;
                            shreg   <= load ? {hold[27:0], 4'h0}
                                            : {shreg[27:0], 4'h0};
                        end
                    end
                end
                ST_CRC: begin
                    if (go) begin
                        if (cnt == CNT_W'(15)) begin
                            state   <= ST_END;
                            bus_out <= 4'hF;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            bus_out <= crc_msb;
                        end
                    end
                end
                ST_END: begin
                    if (fall_ev) begin
                        bus_oe <= 1'b0;
`ifdef SD_DAT_CRC_STATUS_EN
                        state  <= ST_TOKWAIT;
                        cnt    <= '0;
`else
                        state  <= ST_IDLE;
                        done   <= 1'b1;
`endif
                    end
                end
`ifdef SD_DAT_CRC_STATUS_EN
                ST_TOKWAIT: begin
                    if (rise_ev && !quit) begin
                        if (!bidir_port[0]) begin
                            state <= ST_TOKEN;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(TOKEN_TIMEOUT - 1)) begin
                            tokerr <= 1'b1;
                            quit   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    if (fall_ev && quit) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        quit  <= 1'b0;
                    end
                end
                ST_TOKEN: begin
                    if (rise_ev) begin
                        if (cnt == CNT_W'(3)) begin
                            crcerr <= tok != TOKEN_OK;
                            state  <= ST_BUSYWAIT;
                        end else begin
                            tok <= {tok[1:0], bidir_port[0]};
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_BUSYWAIT: begin
                    if (rise_ev && bidir_port[0]) quit <= 1'b1;
                    if (fall_ev && quit) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        quit  <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
